// File: rtl/writeback_arbiter.sv
// Writeback stage feeding the register file's single write port.
// ALU results always win; load results queue in a small FIFO and fill idle cycles.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          AluValid,
  input  logic [4:0]    AluReg,
  input  logic [31:0]   AluData,
  output logic          AluStall,
  input  logic          MemValid,
  output logic          MemReady,
  input  logic [4:0]    MemReg,
  input  logic [31:0]   MemData,
  output logic          RegWrite,
  output logic [4:0]    WriteRegister,
  output logic [31:0]   WriteData,
  output logic [31:0]   Pending,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] rdPtrReg;
  logic [AW:0]   countReg;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic [31:0]   entryMask [DEPTH];
  logic [31:0]   pendingAcc;

  assign fifoFull  = (countReg == FullCount);
  assign fifoEmpty = (countReg == '0);
  assign MemReady  = ~fifoFull;
  assign AluStall  = fifoFull;
  assign Count     = countReg;

  // Readiness depends only on registered occupancy, so push never loops back through MemValid.
  assign push = MemValid & ~fifoFull;
  assign pop  = ~AluValid & ~fifoEmpty;

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (push) begin
      regMem[wrPtrReg]  <= MemReg;
      dataMem[wrPtrReg] <= MemData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + 1'b1;
      if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
      unique case ({push, pop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Register 0 results are consumed but never written.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (AluValid) begin
      RegWrite      <= (AluReg != 5'd0);
      WriteRegister <= AluReg;
      WriteData     <= AluData;
    end else if (pop) begin
      RegWrite      <= (regMem[rdPtrReg] != 5'd0);
      WriteRegister <= regMem[rdPtrReg];
      WriteData     <= dataMem[rdPtrReg];
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    logic [AW-1:0] offset;
    assign offset        = AW'(gi) - rdPtrReg;
    assign entryMask[gi] = ({1'b0, offset} < countReg) ? (32'd1 << regMem[gi]) : 32'd0;
  end

  always_comb begin
    pendingAcc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pendingAcc = pendingAcc | entryMask[i];
    end
  end

  assign Pending = pendingAcc & ~32'd1;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes go into per-source queues,
// a negedge monitor pops and compares every register-file write the DUT presents.
module tb_writeback_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        AluStall;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemReg;
  logic [31:0] MemData;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] Pending;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  logic [36:0] aluQ[$];
  logic [36:0] memQ[$];
  logic        aluAtEdge = 1'b0;

  writeback_arbiter #(.DEPTH(4), .AW(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluStall(AluStall),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Pending(Pending), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Which source produced the write now on the outputs.
  always @(posedge Clk) aluAtEdge <= AluValid;

  always @(negedge Clk) begin
    logic [36:0] exp;
    if (Reset_n && RegWrite) begin
      checks++;
      if (aluAtEdge ? (aluQ.size() == 0) : (memQ.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_write: got reg=%0d data=%0h, required no write", WriteRegister, WriteData);
      end else begin
        exp = aluAtEdge ? aluQ.pop_front() : memQ.pop_front();
        if ({WriteRegister, WriteData} !== exp) begin
          errors++;
          $display("FAIL write_%s: got reg=%0d data=%0h, required reg=%0d data=%0h",
                   aluAtEdge ? "alu" : "mem", WriteRegister, WriteData, exp[36:32], exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    AluValid = 1'b0; AluReg = '0; AluData = '0;
    MemValid = 1'b0; MemReg = '0; MemData = '0;
  endtask

  task automatic driveAlu(input logic [4:0] r, input logic [31:0] d, input bit expectWrite);
    AluValid = 1'b1; AluReg = r; AluData = d;
    if (expectWrite) aluQ.push_back({r, d});
  endtask

  task automatic driveMem(input logic [4:0] r, input logic [31:0] d, input bit expectWrite);
    MemValid = 1'b1; MemReg = r; MemData = d;
    if (expectWrite) memQ.push_back({r, d});
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    tick();
    tick();
    chk("reset_regwrite", 37'(RegWrite), 37'd0);
    chk("reset_count", 37'(Count), 37'd0);
    chk("reset_pending", 37'(Pending), 37'd0);
    chk("reset_alustall", 37'(AluStall), 37'd0);
    Reset_n = 1'b1;
    #1;
    chk("reset_memready", 37'(MemReady), 37'd1);

    // 1: ALU write appears the cycle after it is offered.
    driveAlu(5'd5, 32'hDEADBEEF, 1'b1);
    tick();
    chk("t1_regwrite", 37'(RegWrite), 37'd1);
    chk("t1_reg", 37'(WriteRegister), 37'd5);
    idle();
    tick();

    // 2: single load through an empty FIFO.
    driveMem(5'd7, 32'h11, 1'b1);
    tick();
    idle();
    chk("t2_count_after_push", 37'(Count), 37'd1);
    chk("t2_pending7", 37'(Pending), 37'h80);
    chk("t2_no_bypass", 37'(RegWrite), 37'd0);
    tick();
    chk("t2_regwrite", 37'(RegWrite), 37'd1);
    chk("t2_data", 37'(WriteData), 37'h11);
    chk("t2_pending_clear", 37'(Pending), 37'd0);
    chk("t2_count_empty", 37'(Count), 37'd0);
    tick();

    // 3: fill while the ALU holds the port, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      driveAlu(5'(20 + i), 32'hA0 + 32'(i), 1'b1);
      driveMem(5'(i), 32'h100 + 32'(i), 1'b1);
      tick();
    end
    chk("t3_count_full", 37'(Count), 37'd4);
    chk("t3_memready", 37'(MemReady), 37'd0);
    chk("t3_alustall", 37'(AluStall), 37'd1);
    chk("t3_pending", 37'(Pending), 37'h1E);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_drain_regwrite", 37'(RegWrite), 37'd1);
      chk("t3_drain_order", 37'(WriteRegister), 37'(i));
    end
    tick();
    chk("t3_count_empty", 37'(Count), 37'd0);
    chk("t3_alustall_clear", 37'(AluStall), 37'd0);

    // 4: steady push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 2) driveAlu(5'(25 + i), 32'hC00 + 32'(i), 1'b1);
      driveMem(5'(8 + i), 32'h4000 + 32'(i), 1'b1);
      tick();
      if (i >= 2) chk("t4_count_steady", 37'(Count), 37'd2);
    end
    idle();
    tick();
    tick();
    chk("t4_count_drained", 37'(Count), 37'd0);
    tick();

    // 5: register 0 from both sources is consumed silently.
    driveAlu(5'd0, 32'hBAD, 1'b0);
    driveMem(5'd0, 32'hBAD0, 1'b0);
    tick();
    idle();
    chk("t5_alu_r0_regwrite", 37'(RegWrite), 37'd0);
    chk("t5_count", 37'(Count), 37'd1);
    chk("t5_pending0", 37'(Pending), 37'd0);
    tick();
    chk("t5_mem_r0_regwrite", 37'(RegWrite), 37'd0);
    chk("t5_count_popped", 37'(Count), 37'd0);
    tick();

    // 6: asynchronous reset mid-cycle with three queued loads.
    for (int i = 0; i < 3; i++) begin
      // The last ALU write is wiped by reset before the monitor would sample it.
      driveAlu(5'(26 + i), 32'hE00 + 32'(i), i < 2);
      driveMem(5'(9 + i), 32'h900 + 32'(i), 1'b0);
      tick();
    end
    idle();
    chk("t6_count_before", 37'(Count), 37'd3);
    chk("t6_regwrite_before", 37'(RegWrite), 37'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("t6_async_regwrite", 37'(RegWrite), 37'd0);
    chk("t6_async_reg", 37'(WriteRegister), 37'd0);
    chk("t6_async_data", 37'(WriteData), 37'd0);
    chk("t6_async_count", 37'(Count), 37'd0);
    chk("t6_async_pending", 37'(Pending), 37'd0);
    tick();
    Reset_n = 1'b1;
    #1;
    chk("t6_memready", 37'(MemReady), 37'd1);
    driveMem(5'd12, 32'hC0DE, 1'b1);
    tick();
    idle();
    chk("t6_pending12", 37'(Pending), 37'h1000);
    tick();
    chk("t6_regwrite", 37'(RegWrite), 37'd1);
    chk("t6_data", 37'(WriteData), 37'hC0DE);
    tick();
    tick();

    chk("alu_queue_empty", 37'(aluQ.size()), 37'd0);
    chk("mem_queue_empty", 37'(memQ.size()), 37'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
